// File: rtl/mc_control.sv
// Multicycle control FSM for the RV32I subset core.
// Sequences fetch/decode/execute/memory/writeback, drives the ALU operation,
// handshakes with the unified memory and tracks illegal-op, bus-timeout and
// retired-instruction status.
module mc_control #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             z,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int             WCW      = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  // Current state; kept as a named enum so checkers can bind to it directly.
  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [2:0]     alu_dec;
  logic           alu_ok;
  logic           stall;
  logic           timeout;
  logic           retire;

  // ALU operation for EXECR/EXECI; funct7b5 selects sub only for R-type.
  always_comb begin
    alu_ok  = 1'b1;
    alu_dec = 3'b000;
    case (funct3)
      3'b000:  alu_dec = (state == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
      3'b111:  alu_dec = 3'b010;
      3'b110:  alu_dec = 3'b011;
      3'b010:  alu_dec = 3'b101;
      default: alu_ok  = 1'b0;
    endcase
  end

  // A request waits while mem_req is up without mem_ready; mem_ready on the
  // final allowed cycle still completes, so timeout requires it to be low.
  assign stall   = mem_req & ~mem_ready;
  assign timeout = stall && (wait_cnt == WAIT_LIM);
  assign retire  = (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BEQ) ||
                   (state == S_MEMWR && mem_ready);

  // State sequencing, wait counter, sticky error flags and retire counter.
  // Every stall cycle is one where the state is held, so clearing the
  // counter on any non-stall cycle also clears it on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= (stall && !timeout) ? wait_cnt + WCW'(1) : '0;
      if (retire) instret <= instret + CNT_W'(1);
      if (timeout) begin
        state   <= S_TRAP;
        bus_err <= 1'b1;
      end else begin
        case (state)
          S_BOOT:   state <= S_FETCH;
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            case (op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_R:         state <= S_EXECR;
              OP_I:         state <= S_EXECI;
              OP_JAL:       state <= S_JAL;
              OP_BR: begin
                if (funct3 == 3'b000) begin
                  state <= S_BEQ;
                end else begin
                  state   <= S_TRAP;
                  illegal <= 1'b1;
                end
              end
              default: begin
                state   <= S_TRAP;
                illegal <= 1'b1;
              end
            endcase
          end
          S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
          S_MEMRD:  if (mem_ready) state <= S_MEMWB;
          S_MEMWB:  state <= S_FETCH;
          S_MEMWR:  if (mem_ready) state <= S_FETCH;
          S_EXECR, S_EXECI: begin
            if (alu_ok) begin
              state <= S_ALUWB;
            end else begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          end
          S_ALUWB:  state <= S_FETCH;
          S_BEQ:    state <= S_FETCH;
          S_JAL:    state <= S_ALUWB;
          S_TRAP:   state <= S_TRAP;
          default:  state <= S_BOOT;
        endcase
      end
    end
  end

  // Moore output decode from the state register; ir_write/pc_write in FETCH
  // and pc_write in BEQ are gated by mem_ready and z. Decoding from the state
  // register makes an asynchronous reset clear every output immediately.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 2'b00;
    alu_ctrl   = 3'b000;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_BR) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_dec;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_ctrl  = 3'b001;
        pc_write  = z;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: a table of per-cycle vectors for the
// zero/low-wait instruction mix, plus hand-written sequences for timeouts,
// illegal instructions and asynchronous reset.
module tb_mc_control;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       op = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7b5 = 1'b0;
  logic             z = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]       alu_ctrl;
  logic             illegal, bus_err;
  logic [CNT_W-1:0] instret;

  mc_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .z(z), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  // Clock: 10-unit period; inputs change and outputs are sampled near negedge.
  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal, bus_err};

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic             rdy;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic             z;
    logic [18:0]      exp;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Output word builder, same field order as act.
  function automatic logic [18:0] o(input logic mr, mw, as, iw, pw, rw,
                                    input logic [1:0] a, b, rs, imm,
                                    input logic [2:0] alu, input logic ill, be);
    return {mr, mw, as, iw, pw, rw, a, b, rs, imm, alu, ill, be};
  endfunction

  // Hand-written expected outputs per state.
  function automatic logic [18:0] ef(input logic rdy);
    return o(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] ed(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] er(input logic [2:0] alu);
    return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [18:0] ei(input logic [2:0] alu);
    return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [18:0] ewb();
    return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] eb(input logic zz);
    return o(0, 0, 0, 0, zz, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0);
  endfunction
  function automatic logic [18:0] ej();
    return o(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] ema(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] emr();
    return o(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] emwb();
    return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] emw();
    return o(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] et(input logic ill, be);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, ill, be);
  endfunction

  // Driver tasks.
  task automatic push(input logic rdy, input logic [6:0] o_, input logic [2:0] f3,
                      input logic f7, input logic zz, input logic [18:0] exp,
                      input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.rdy = rdy; v.op = o_; v.f3 = f3; v.f7 = f7; v.z = zz; v.exp = exp; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rdy, input logic [6:0] o_, input logic [2:0] f3,
                       input logic f7, input logic zz);
    mem_ready = rdy; op = o_; funct3 = f3; funct7b5 = f7; z = zz;
  endtask

  task automatic check(input string name, input logic [18:0] exp,
                       input logic [CNT_W-1:0] exp_cnt);
    n_vec++;
    if (act !== exp || instret !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s: outputs=%05h instret=%0d, expected outputs=%05h instret=%0d",
               name, act, instret, exp, exp_cnt);
    end
  endtask

  // One cycle: called at a negedge, drives, checks, advances to next negedge.
  task automatic step(input string name, input logic rdy, input logic [6:0] o_,
                      input logic [2:0] f3, input logic f7, input logic zz,
                      input logic [18:0] exp, input logic [CNT_W-1:0] cnt);
    drive(rdy, o_, f3, f7, zz);
    #1 check(name, exp, cnt);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse asserted between edges; outputs must clear at once.
  task automatic areset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Four-cycle ALU instruction (R/I-type) with zero-wait fetch.
  task automatic push_alu(input logic [6:0] o_, input logic [2:0] f3, input logic f7,
                          input logic [18:0] exec_exp, input logic [CNT_W-1:0] cnt);
    push(1, o_, f3, f7, 0, ef(1), cnt);
    push(1, o_, f3, f7, 0, ed(2'b00), cnt);
    push(1, o_, f3, f7, 0, exec_exp, cnt);
    push(1, o_, f3, f7, 0, ewb(), cnt);
  endtask

  initial begin
    // Vector table: per-cycle inputs with hand-computed outputs and instret.
    push(1, OP_R, 3'b000, 0, 0, '0, 0);                  // BOOT
    push_alu(OP_R, 3'b000, 0, er(3'b000), 0);            // add
    push_alu(OP_R, 3'b000, 1, er(3'b001), 1);            // sub
    push_alu(OP_R, 3'b111, 0, er(3'b010), 2);            // and
    push_alu(OP_R, 3'b110, 0, er(3'b011), 3);            // or
    push_alu(OP_R, 3'b010, 0, er(3'b101), 4);            // slt
    push_alu(OP_I, 3'b000, 1, ei(3'b000), 5);            // addi, funct7b5 ignored
    push(1, OP_BR, 3'b000, 0, 1, ef(1), 6);              // beq taken
    push(1, OP_BR, 3'b000, 0, 1, ed(2'b10), 6);
    push(1, OP_BR, 3'b000, 0, 1, eb(1), 6);
    push(1, OP_BR, 3'b000, 0, 0, ef(1), 7);              // beq not taken
    push(1, OP_BR, 3'b000, 0, 0, ed(2'b10), 7);
    push(1, OP_BR, 3'b000, 0, 0, eb(0), 7);
    push(1, OP_JAL, 3'b000, 0, 0, ef(1), 8);             // jal
    push(1, OP_JAL, 3'b000, 0, 0, ed(2'b11), 8);
    push(1, OP_JAL, 3'b000, 0, 0, ej(), 8);
    push(1, OP_JAL, 3'b000, 0, 0, ewb(), 8);
    for (int i = 0; i < 3; i++) push(0, OP_LW, 3'b010, 0, 0, ef(0), 9);  // lw, fetch waits
    push(1, OP_LW, 3'b010, 0, 0, ef(1), 9);
    push(1, OP_LW, 3'b010, 0, 0, ed(2'b00), 9);
    push(1, OP_LW, 3'b010, 0, 0, ema(2'b00), 9);
    for (int i = 0; i < 2; i++) push(0, OP_LW, 3'b010, 0, 0, emr(), 9);
    push(1, OP_LW, 3'b010, 0, 0, emr(), 9);
    push(1, OP_LW, 3'b010, 0, 0, emwb(), 9);
    push(1, OP_SW, 3'b010, 0, 0, ef(1), 10);             // sw zero-wait
    push(1, OP_SW, 3'b010, 0, 0, ed(2'b00), 10);
    push(1, OP_SW, 3'b010, 0, 0, ema(2'b01), 10);
    push(1, OP_SW, 3'b010, 0, 0, emw(), 10);

    // Reset state check, then release and run the table.
    drive(0, '0, '0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check("reset_state", '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].op, vecs[i].f3, vecs[i].f7,
           vecs[i].z, vecs[i].exp, vecs[i].cnt);

    // sw with memory never ready: 16 wait cycles, then TRAP with bus_err.
    step("sw_to_fetch", 1, OP_SW, 3'b010, 0, 0, ef(1), 11);
    step("sw_decode", 1, OP_SW, 3'b010, 0, 0, ed(2'b00), 11);
    step("sw_memadr", 1, OP_SW, 3'b010, 0, 0, ema(2'b01), 11);
    for (int i = 0; i < WAIT_MAX + 1; i++)
      step($sformatf("sw_wait%0d", i), 0, OP_SW, 3'b010, 0, 0, emw(), 11);
    for (int i = 0; i < 3; i++)
      step($sformatf("sw_trap%0d", i), 1, OP_SW, 3'b010, 0, 0, et(0, 1), 11);
    areset("reset_clears_bus_err");
    step("boot_after_bus_err", 1, OP_SYS, 3'b000, 0, 0, '0, 0);

    // Fetch waits WAIT_MAX cycles; mem_ready on the limit cycle still completes.
    for (int i = 0; i < WAIT_MAX; i++)
      step($sformatf("fetch_wait%0d", i), 0, OP_SYS, 3'b000, 0, 0, ef(0), 0);
    step("fetch_ready_at_limit", 1, OP_SYS, 3'b000, 0, 0, ef(1), 0);
    step("sys_decode", 1, OP_SYS, 3'b000, 0, 0, ed(2'b00), 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("sys_trap%0d", i), 1, OP_SYS, 3'b000, 0, 0, et(1, 0), 0);
    areset("reset_clears_illegal");
    step("boot_after_illegal", 1, OP_R, 3'b001, 0, 0, '0, 0);

    // R-type with unsupported funct3 traps from EXECR instead of writing back.
    step("r001_fetch", 1, OP_R, 3'b001, 0, 0, ef(1), 0);
    step("r001_decode", 1, OP_R, 3'b001, 0, 0, ed(2'b00), 0);
    drive(1, OP_R, 3'b001, 0, 0);
    @(negedge clk);
    step("r001_trap", 1, OP_R, 3'b001, 0, 0, et(1, 0), 0);
    areset("reset_after_r001");
    step("boot_before_lw", 1, OP_I, 3'b110, 0, 0, '0, 0);

    // ori retires, then reset asserted in the middle of a waiting lw read.
    push_alu(OP_I, 3'b110, 0, ei(3'b011), 0);
    for (int i = vecs.size() - 4; i < vecs.size(); i++)
      step($sformatf("ori%0d", i), vecs[i].rdy, vecs[i].op, vecs[i].f3, vecs[i].f7,
           vecs[i].z, vecs[i].exp, vecs[i].cnt);
    step("lw_fetch", 1, OP_LW, 3'b010, 0, 0, ef(1), 1);
    step("lw_decode", 1, OP_LW, 3'b010, 0, 0, ed(2'b00), 1);
    step("lw_memadr", 1, OP_LW, 3'b010, 0, 0, ema(2'b00), 1);
    drive(0, OP_LW, 3'b010, 0, 0);
    #1 check("lw_memrd_wait", emr(), 1);
    areset("reset_mid_memrd");
    step("boot_after_memrd_reset", 0, OP_LW, 3'b010, 0, 0, '0, 0);
    step("fetch_after_memrd_reset", 0, OP_LW, 3'b010, 0, 0, ef(0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Time limit so the bench always ends on its own.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, required finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
